hex_display_sequencer: RTL

Converts a 16-bit binary value into four seven-segment digit codes and writes them to the HEX3–HEX0 parallel output port. The block is an Avalon-MM master that accepts a value over a valid/ready handshake and converts it to BCD with a sequential double-dabble engine. It then issues one 32-bit write to the HEX PIO data register at offset 0. It sits between application logic and the HEX3_HEX0 PIO slave in the Computer_System.

---
 rtl/hex_display_sequencer.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/hex_display_sequencer.sv
// Binary-to-seven-segment sequencer: double-dabble BCD conversion, then one Avalon-MM write to the HEX3_HEX0 PIO.
// Optional leading-zero blanking of HEX3..HEX1 is enabled by defining HEX_SEQ_LZB_EN.
module hex_display_sequencer (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_value,
    output logic        done,
    output logic [1:0]  m_address,
    output logic        m_chipselect,
    output logic        m_write_n,
    output logic [31:0] m_writedata,
    input  logic        m_waitrequest
);

    // Handshake: a value is taken on any rising edge where in_valid && in_ready;
    // in_ready is high only in IDLE, so in_valid in any other state is ignored.
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CONVERT = 3'd1,
        S_ENCODE  = 3'd2,
        S_WRITE   = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t      state;
    state_t      next_state;
    logic [15:0] shift_q;
    logic [19:0] bcd_q;
    logic [4:0]  count_q;
    logic [19:0] bcd_adj;
    logic [31:0] seg_image;
    logic        overflow;
    logic [6:0]  seg0, seg1, seg2, seg3;

    function automatic logic [6:0] seg7(input logic [3:0] digit);
        case (digit)
            4'd0:    seg7 = 7'h3F;
            4'd1:    seg7 = 7'h06;
            4'd2:    seg7 = 7'h5B;
            4'd3:    seg7 = 7'h4F;
            4'd4:    seg7 = 7'h66;
            4'd5:    seg7 = 7'h6D;
            4'd6:    seg7 = 7'h7D;
            4'd7:    seg7 = 7'h07;
            4'd8:    seg7 = 7'h7F;
            4'd9:    seg7 = 7'h6F;
            default: seg7 = 7'h00;
        endcase
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:    if (in_valid) next_state = S_CONVERT;
            S_CONVERT: if (count_q == 5'd15) next_state = S_ENCODE;
            S_ENCODE:  next_state = S_WRITE;
            S_WRITE:   if (!m_waitrequest) next_state = S_DONE;
            S_DONE:    next_state = S_IDLE;
            default:   next_state = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state == S_IDLE);
        done     = (state == S_DONE);
    end

    assign m_address = 2'b00;

    // Double-dabble add-3 step applied to every BCD nibble before the shift.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < 5; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    // A non-zero ten-thousands digit means the value cannot fit four digits.
    always_comb begin
        overflow = (bcd_q[19:16] != 4'd0);
        seg0     = seg7(bcd_q[3:0]);
        seg1     = seg7(bcd_q[7:4]);
        seg2     = seg7(bcd_q[11:8]);
        seg3     = seg7(bcd_q[15:12]);
`ifdef HEX_SEQ_LZB_EN
        if (bcd_q[15:12] == 4'd0) begin
            seg3 = 7'h00;
            if (bcd_q[11:8] == 4'd0) begin
                seg2 = 7'h00;
                if (bcd_q[7:4] == 4'd0) begin
                    seg1 = 7'h00;
                end
            end
        end
`else
        seg3 = seg7(bcd_q[15:12]);
`endif
        if (overflow) begin
            seg_image = 32'h4040_4040;
        end else begin
            seg_image = {1'b0, seg3, 1'b0, seg2, 1'b0, seg1, 1'b0, seg0};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shift_q     <= 16'd0;
            bcd_q       <= 20'd0;
            count_q     <= 5'd0;
            m_writedata <= 32'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        shift_q <= in_value;
                        bcd_q   <= 20'd0;
                        count_q <= 5'd0;
                    end
                end
                S_CONVERT: begin
                    {bcd_q, shift_q} <= {bcd_adj, shift_q} << 1;
                    count_q          <= count_q + 5'd1;
                end
                S_ENCODE: m_writedata <= seg_image;
                default: ;
            endcase
        end
    end

    // Strobes are registered from next_state so they line up exactly with WRITE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_chipselect <= 1'b0;
            m_write_n    <= 1'b1;
        end else begin
            m_chipselect <= (next_state == S_WRITE);
            m_write_n    <= (next_state != S_WRITE);
        end
    end

endmodule
